// File: rtl/mnist_vote_pkg.sv
// Shared types and constants for the MNIST temporal class voter.
// Hysteresis on publication is enabled by defining MNIST_CLASS_VOTER_HYST_EN.
package mnist_vote_pkg;
  localparam int         CLASS_NUM_DEF = 10;
  localparam logic [3:0] CLS_UNKNOWN   = 4'hF;
  localparam logic [3:0] CLS_NONE_CAND = 4'hE;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;
endpackage

// File: rtl/mnist_vote_counter_bank.sv
// Per-class saturating vote counters with synchronous clear and an indexed read port.
module mnist_vote_counter_bank #(
  parameter int CLASS_NUM     = 10,
  parameter int WINDOW_FRAMES = 8,
  parameter int CNT_W         = 4,
  parameter int IDX_W         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 clr_i,
  input  logic [CLASS_NUM-1:0] inc_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [CNT_W-1:0]     cnt_o
);
  logic [CNT_W-1:0] cnt_q [CLASS_NUM];
  logic [CNT_W-1:0] cnt_d [CLASS_NUM];

  always_comb begin
    for (int i = 0; i < CLASS_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_i)
        cnt_d[i] = '0;
      else if (inc_i[i] && (cnt_q[i] != CNT_W'(WINDOW_FRAMES)))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CLASS_NUM; i++) begin
      if (reset)
        cnt_q[i] <= '0;
      else if (cke)
        cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < CLASS_NUM; i++)
      if (idx_i == IDX_W'(i)) cnt_o = cnt_q[i];
  end
endmodule

// File: rtl/mnist_class_voter.sv
// Temporal majority voter: accumulates per-frame class votes, sequential argmax, publishes the winner.
// Define MNIST_CLASS_VOTER_HYST_EN to publish only when two consecutive windows agree.
module mnist_class_voter
  import mnist_vote_pkg::*;
#(
  parameter  int CLASS_NUM     = CLASS_NUM_DEF,
  parameter  int WINDOW_FRAMES = 8,
  parameter  int MIN_VOTES     = 5,
  localparam int CNT_W         = $clog2(WINDOW_FRAMES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 in_vsync,
  input  logic [CLASS_NUM-1:0] in_class,
  output logic [3:0]           out_class,
  output logic [CLASS_NUM-1:0] out_onehot,
  output logic [CNT_W-1:0]     out_votes,
  output logic                 out_valid,
  output logic                 out_update
);
  localparam int IDX_W = $clog2(CLASS_NUM);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     frame_q, frame_d;
  logic                 vs_q;
  logic                 pend_vld_q, pend_vld_d;
  logic [CLASS_NUM-1:0] pend_cls_q, pend_cls_d;
  logic [CNT_W-1:0]     best_votes_q, best_votes_d;
  logic [3:0]           best_idx_q, best_idx_d;
  logic [3:0]           out_class_q, out_class_d;
  logic [CNT_W-1:0]     out_votes_q, out_votes_d;
  logic                 out_update_q, out_update_d;
  logic [3:0]           cand_q, cand_d;

  logic                 vs_edge, apply, clr;
  logic [CLASS_NUM-1:0] apply_cls;
  logic [CNT_W-1:0]     rd_cnt;
  logic [3:0]           res_cls;

  assign vs_edge = cke & in_vsync & ~vs_q;

  mnist_vote_counter_bank #(
    .CLASS_NUM    (CLASS_NUM),
    .WINDOW_FRAMES(WINDOW_FRAMES),
    .CNT_W        (CNT_W),
    .IDX_W        (IDX_W)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .cke  (cke),
    .clr_i(clr),
    .inc_i(apply ? apply_cls : '0),
    .idx_i(idx_q),
    .cnt_o(rd_cnt)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    pend_vld_d   = pend_vld_q;
    pend_cls_d   = pend_cls_q;
    best_votes_d = best_votes_q;
    best_idx_d   = best_idx_q;
    out_class_d  = out_class_q;
    out_votes_d  = out_votes_q;
    out_update_d = 1'b0;
    cand_d       = cand_q;
    apply        = 1'b0;
    apply_cls    = '0;
    clr          = 1'b0;
    res_cls      = (best_votes_q >= CNT_W'(MIN_VOTES)) ? best_idx_q : CLS_UNKNOWN;
    case (state_q)
      ACCUM: begin
        // A held sample always goes first; a simultaneous new edge takes its place.
        if (pend_vld_q) begin
          apply      = 1'b1;
          apply_cls  = pend_cls_q;
          pend_vld_d = vs_edge;
          if (vs_edge) pend_cls_d = in_class;
        end else if (vs_edge) begin
          apply     = 1'b1;
          apply_cls = in_class;
        end
        if (apply) begin
          frame_d = frame_q + 1'b1;
          if (frame_q + 1'b1 == CNT_W'(WINDOW_FRAMES)) begin
            state_d      = SCAN;
            idx_d        = '0;
            best_votes_d = '0;
            best_idx_d   = '0;
          end
        end
      end
      SCAN: begin
        if (vs_edge) begin
          pend_vld_d = 1'b1;
          pend_cls_d = in_class;
        end
        if (rd_cnt > best_votes_q) begin
          best_votes_d = rd_cnt;
          best_idx_d   = 4'(idx_q);
        end
        if (idx_q == IDX_W'(CLASS_NUM - 1))
          state_d = DECIDE;
        else
          idx_d = idx_q + 1'b1;
      end
      DECIDE: begin
        if (vs_edge) begin
          pend_vld_d = 1'b1;
          pend_cls_d = in_class;
        end
        clr          = 1'b1;
        frame_d      = '0;
        state_d      = ACCUM;
        out_update_d = 1'b1;
`ifdef MNIST_CLASS_VOTER_HYST_EN
        if (res_cls == cand_q) begin
          out_class_d = res_cls;
          out_votes_d = best_votes_q;
        end
        cand_d = res_cls;
`else
        out_class_d = res_cls;
        out_votes_d = best_votes_q;
`endif
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      idx_q        <= '0;
      frame_q      <= '0;
      vs_q         <= 1'b1;
      pend_vld_q   <= 1'b0;
      out_class_q  <= CLS_UNKNOWN;
      out_votes_q  <= '0;
      out_update_q <= 1'b0;
      cand_q       <= CLS_NONE_CAND;
    end else if (cke) begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      vs_q         <= in_vsync;
      pend_vld_q   <= pend_vld_d;
      out_class_q  <= out_class_d;
      out_votes_q  <= out_votes_d;
      out_update_q <= out_update_d;
      cand_q       <= cand_d;
    end
  end

  // Payload regs are qualified by pend_vld_q / the SCAN entry init, so they need no reset.
  always_ff @(posedge clk) begin
    if (cke) begin
      pend_cls_q   <= pend_cls_d;
      best_votes_q <= best_votes_d;
      best_idx_q   <= best_idx_d;
    end
  end

  always_comb begin
    out_onehot = '0;
    for (int i = 0; i < CLASS_NUM; i++)
      out_onehot[i] = (out_class_q == 4'(i));
  end

  assign out_class  = out_class_q;
  assign out_votes  = out_votes_q;
  assign out_valid  = (out_class_q != CLS_UNKNOWN);
  assign out_update = out_update_q;
endmodule

// File: tb/tb_mnist_class_voter.sv
// Scoreboard bench for mnist_class_voter: directed windows, pending edge, reset abort, clock-enable stall.
module tb_mnist_class_voter;
  logic       clk = 1'b0;
  logic       reset, cke, in_vsync;
  logic [9:0] in_class;
  logic [3:0] out_class;
  logic [9:0] out_onehot;
  logic [3:0] out_votes;
  logic       out_valid, out_update;

  mnist_class_voter dut (
    .clk       (clk),
    .reset     (reset),
    .cke       (cke),
    .in_vsync  (in_vsync),
    .in_class  (in_class),
    .out_class (out_class),
    .out_onehot(out_onehot),
    .out_votes (out_votes),
    .out_valid (out_valid),
    .out_update(out_update)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_p = 0;

  typedef struct {
    logic [3:0] cls;
    logic [3:0] votes;
    int         at;
  } exp_t;
  exp_t q[$];

  logic [3:0] m_cls  = 4'hF;
  logic [3:0] m_vot  = 4'h0;
  logic [3:0] m_cand = 4'hE;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cls  = 4'hF;
    m_vot  = 4'h0;
    m_cand = 4'hE;
  endtask

  task automatic push_win(input logic [3:0] rc, input logic [3:0] rv, input int at);
    exp_t e;
`ifdef MNIST_CLASS_VOTER_HYST_EN
    if (rc == m_cand) begin
      m_cls = rc;
      m_vot = rv;
    end
    m_cand = rc;
`else
    m_cls = rc;
    m_vot = rv;
`endif
    e.cls   = m_cls;
    e.votes = m_vot;
    e.at    = at;
    q.push_back(e);
  endtask

  function automatic int onehot_of(input logic [3:0] c);
    return (c < 4'd10) ? (1 << c) : 0;
  endfunction

  always @(negedge clk) begin
    if (out_update === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_update: got class %0d expected no update (cycle %0d)", out_class, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("upd_class", int'(out_class), int'(e.cls));
        check("upd_valid", int'(out_valid), int'(e.cls != 4'hF));
        check("upd_onehot", int'(out_onehot), onehot_of(e.cls));
        check("upd_cycle", cyc, e.at);
        if (e.cls != 4'hF) check("upd_votes", int'(out_votes), int'(e.votes));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [9:0] c);
    in_class = c;
    in_vsync = 1'b1;
    last_p   = cyc + 1;
    @(negedge clk);
    in_vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input logic [9:0] c, input int n);
    for (int i = 0; i < n; i++) frame(c);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_class"}, int'(out_class), 15);
    check({tag, "_onehot"}, int'(out_onehot), 0);
    check({tag, "_votes"}, int'(out_votes), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_update"}, int'(out_update), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    cke      = 1'b1;
    in_vsync = 1'b1;
    in_class = '0;
    idle(3);
    reset = 1'b0;
    idle(5);
    check_idle_outputs("reset");
    in_vsync = 1'b0;
    idle(2);

    // Single class for a full window.
    frames(10'h008, 8);
    push_win(4'd3, 4'd8, last_p + 11);
    idle(14);

    // Tie at 4 votes, below the minimum.
    frames(10'h080, 4);
    frames(10'h004, 4);
    push_win(4'hF, 4'd4, last_p + 11);
    idle(14);

    // Zero-hot frames count as frames only.
    frames(10'h200, 5);
    frames(10'h000, 3);
    push_win(4'd9, 4'd5, last_p + 11);
    idle(14);

    // Multi-hot votes.
    frames(10'h012, 6);
    frames(10'h010, 2);
    push_win(4'd4, 4'd8, last_p + 11);
    idle(14);

    // Edges during SCAN are held; the newer one replaces the older.
    frames(10'h008, 8);
    push_win(4'd3, 4'd8, last_p + 11);
    idle(1);
    frame(10'h020);
    frame(10'h040);
    idle(12);
    frames(10'h040, 7);
    push_win(4'd6, 4'd8, last_p + 11);
    idle(14);

    // Reset during SCAN aborts the window and clears the counters.
    frames(10'h002, 8);
    idle(2);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_reset();
    idle(15);
    check_idle_outputs("abort");
    frames(10'h004, 8);
    push_win(4'd2, 4'd8, last_p + 11);
    idle(14);

    // Clock enable low for 20 cycles mid-SCAN delays the result by 20.
    frames(10'h100, 8);
    push_win(4'd8, 4'd8, last_p + 11 + 20);
    idle(1);
    cke = 1'b0;
    idle(20);
    cke = 1'b1;
    idle(20);

`ifdef MNIST_CLASS_VOTER_HYST_EN
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_reset();
    idle(2);
    frames(10'h020, 3);
    frames(10'h000, 5);
    push_win(4'hF, 4'd3, last_p + 11);
    idle(14);
    frames(10'h020, 5);
    frames(10'h000, 3);
    push_win(4'd5, 4'd5, last_p + 11);
    idle(14);
    frames(10'h020, 5);
    frames(10'h000, 3);
    push_win(4'd5, 4'd5, last_p + 11);
    idle(14);
`endif

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
